// File: rtl/parent_sched.sv
`default_nettype none
// ============================================================================
// Module      : parent_sched
// Description : Round-robin scheduler that arbitrates child requests, wakes a
//               parent, waits for its food/book responses with a timeout, and
//               reports completion, errors and a saturating service count.
// Revision    : 1.0 - initial release
// ============================================================================
module parent_sched #(
    parameter int N_CHILD = 4,
    parameter int TIMEOUT = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CHILD-1:0] req,
    input  logic               food,
    input  logic               book,
    output logic               wakeup,
    output logic [N_CHILD-1:0] grant,
    output logic [N_CHILD-1:0] done,
    output logic               busy,
    output logic               err,
    output logic [7:0]         serve_cnt
);

    localparam int c_PW = $clog2(N_CHILD);
    localparam int c_TW = $clog2(TIMEOUT);
    localparam logic [c_TW-1:0] c_TMAX    = c_TW'(TIMEOUT - 1);
    // Pointing at the last index makes index 0 the first candidate after reset
    localparam logic [c_PW-1:0] c_PTR_RST = c_PW'(N_CHILD - 1);

    localparam logic [2:0] c_S_IDLE      = 3'd0;
    localparam logic [2:0] c_S_WAKE      = 3'd1;
    localparam logic [2:0] c_S_WAIT_FOOD = 3'd2;
    localparam logic [2:0] c_S_WAIT_BOOK = 3'd3;
    localparam logic [2:0] c_S_DONE      = 3'd4;

    logic [2:0]         r_state;
    logic [c_PW-1:0]    r_last;
    logic [c_PW-1:0]    r_gidx;
    logic [N_CHILD-1:0] r_grant;
    logic [c_TW-1:0]    r_tcnt;
    logic               r_err;
    logic [7:0]         r_cnt;

    logic [c_PW-1:0]    w_win_idx;
    logic [N_CHILD-1:0] w_win_oh;
    logic               w_found;
    int                 w_cand;
    logic [c_PW-1:0]    w_cand_idx;

    // Round-robin search starting just after the last served child, with wrap
    always_comb begin
        w_win_idx  = r_last;
        w_found    = 1'b0;
        w_cand     = 0;
        w_cand_idx = '0;
        for (int k = 1; k <= N_CHILD; k++) begin
            w_cand     = (int'(r_last) + k) % N_CHILD;
            w_cand_idx = c_PW'(w_cand);
            if (!w_found && req[w_cand_idx]) begin
                w_found   = 1'b1;
                w_win_idx = w_cand_idx;
            end
        end
    end

    // One-hot form of the winner, latched into grant when a service starts
    always_comb begin
        w_win_oh            = '0;
        w_win_oh[w_win_idx] = 1'b1;
    end

    // Control FSM: capture request, handshake with parent under timeout, bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_S_IDLE;
            r_last  <= c_PTR_RST;
            r_gidx  <= '0;
            r_grant <= '0;
            r_tcnt  <= '0;
            r_err   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_found) begin
                        r_state <= c_S_WAKE;
                        r_gidx  <= w_win_idx;
                        r_grant <= w_win_oh;
                    end
                end
                c_S_WAKE: begin
                    r_state <= c_S_WAIT_FOOD;
                    r_tcnt  <= '0;
                end
                c_S_WAIT_FOOD: begin
                    // The awaited input takes precedence over an expiring count
                    if (food) begin
                        r_state <= c_S_WAIT_BOOK;
                        r_tcnt  <= '0;
                    end else if (r_tcnt == c_TMAX) begin
                        r_state <= c_S_IDLE;
                        r_grant <= '0;
                        r_err   <= 1'b1;
                        r_last  <= r_gidx;
                    end else begin
                        r_tcnt <= r_tcnt + c_TW'(1);
                    end
                end
                c_S_WAIT_BOOK: begin
                    if (book) begin
                        r_state <= c_S_DONE;
                    end else if (r_tcnt == c_TMAX) begin
                        r_state <= c_S_IDLE;
                        r_grant <= '0;
                        r_err   <= 1'b1;
                        r_last  <= r_gidx;
                    end else begin
                        r_tcnt <= r_tcnt + c_TW'(1);
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                    r_grant <= '0;
                    r_last  <= r_gidx;
                    if (r_cnt != 8'hFF) begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_state <= c_S_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

    // Outputs decode directly from registered state so they drop with reset
    assign wakeup    = (r_state == c_S_WAKE);
    assign busy      = (r_state != c_S_IDLE);
    assign grant     = r_grant;
    assign done      = (r_state == c_S_DONE) ? r_grant : '0;
    assign err       = r_err;
    assign serve_cnt = r_cnt;

endmodule
`default_nettype wire

// File: doc/parent_sched.md
PARENT_SCHED -- requirements
Module: parent_sched

Interface
REQ-001 SHALL have parameter N_CHILD, default 4, number of requesting children (2..8).
REQ-002 SHALL have parameter TIMEOUT, default 8, max cycles waited for each parent response (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  N_CHILD  per-child service request, level, held by child until its done pulse.
REQ-006 SHALL have port food  input  1  parent food output (high exactly one cycle per service).
REQ-007 SHALL have port book  input  1  parent book output (high exactly one cycle per service).
REQ-008 SHALL have port wakeup  output  1  wake pulse to parent, driven from state register only.
REQ-009 SHALL have port grant  output  N_CHILD  one-hot, child currently being served; zero when idle.
REQ-010 SHALL have port done  output  N_CHILD  one-cycle pulse on the served child's bit at service completion.
REQ-011 SHALL have port busy  output  1  high in every state except IDLE.
REQ-012 SHALL have port err  output  1  sticky timeout flag.
REQ-013 SHALL have port serve_cnt  output  8  count of completed services, saturating.

Function
REQ-014 SHALL implement states IDLE, WAKE, WAIT_FOOD, WAIT_BOOK, DONE.
REQ-015 IDLE: any req bit high -> WAKE, latching the round-robin winner into grant on the same edge; else stay.
REQ-016 WAKE: wakeup=1 for exactly this one cycle -> WAIT_FOOD unconditionally.
REQ-017 WAIT_FOOD: food=1 -> WAIT_BOOK; else timeout check (REQ-021).
REQ-018 WAIT_BOOK: book=1 -> DONE; else timeout check.
REQ-019 DONE: done[g]=1 for granted index g, serve_cnt+1 (held at 255), pointer update, grant cleared on exit -> IDLE.
REQ-020 Nominal timing: req seen in IDLE cycle i -> wakeup cycle i+1, food seen i+3, book seen i+4, done pulse i+5, IDLE i+6.
REQ-021 Timeout counter cleared on entry to WAIT_FOOD and WAIT_BOOK, increments each cycle there; on count TIMEOUT-1 without the awaited input -> IDLE, err set, grant cleared, no done pulse, serve_cnt unchanged.
REQ-022 Awaited input and timeout in the same cycle: input wins, no error.
REQ-023 Round-robin: search starts at index (last_served+1) mod N_CHILD, ascending with wrap; pointer updates on DONE and on timeout abort.
REQ-024 Requests sampled only in IDLE; req changes during service ignored; dropping req mid-service does not abort.
REQ-025 food or book arriving in IDLE, WAKE or the wrong wait state SHALL be ignored, no state change, no err.
REQ-026 err cleared only by reset; serve_cnt never wraps.

Reset
REQ-027 reset high SHALL force immediately (asynchronously): state IDLE, wakeup 0, grant 0, done 0, busy 0, err 0, serve_cnt 0, timeout counter 0, pointer such that index 0 has highest priority.
REQ-028 reset mid-service SHALL abandon the service with no done pulse; first post-reset grant follows REQ-027 priority.

Verification
REQ-029 Single request: req=4'b0100 with parent model -> wakeup one cycle after, grant=4'b0100 for 5 cycles, done=4'b0100 pulse at i+5, serve_cnt=1.
REQ-030 All requesting: req=4'b1111 held -> grants in order 0001,0010,0100,1000,0001; each done on matching bit; serve_cnt increments per service.
REQ-031 Timeout: food tied 0, TIMEOUT=8 -> 8 cycles in WAIT_FOOD then IDLE, err=1, no done, next grant goes to next index.
REQ-032 Race: book asserted on the cycle count reaches TIMEOUT-1 -> DONE taken, err stays 0.
REQ-033 Reset asserted during WAIT_BOOK -> outputs all 0 same cycle; after release req=4'b1010 grants 0010 first.
REQ-034 Saturation: 260 back-to-back services -> serve_cnt stops at 255, done pulses continue.
